// File: rtl/key_debounce_ctrl.sv
// Push-button front end: 2-FF synchroniser, debounce FSM, press/release/long-press
// pulses and a wrapping blink-speed index for the downstream LED stage.
module key_debounce_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned NUM_SPEEDS        = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [1:0] speed_sel
);

    localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(LONG_PRESS_CYCLES - 1);
    localparam logic [1:0]  SPD_LAST  = 2'(NUM_SPEEDS - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t      r_state, w_next_state;
    logic        r_s1, r_s2;
    logic [31:0] r_db_cnt, w_db_cnt_nxt;
    logic [31:0] r_hold_cnt, w_hold_cnt_nxt;
    logic        r_long_done, w_long_done_nxt;
    logic        r_level, w_level_nxt;
    logic        r_press, w_press_nxt;
    logic        r_release, w_release_nxt;
    logic        r_long, w_long_nxt;
    logic [1:0]  r_speed, w_speed_nxt;

    logic w_k, w_db_done, w_long_hit, w_rel_done;

    assign w_k        = r_s2 ^ ACTIVE_LOW;
    assign w_db_done  = (r_db_cnt == DB_LAST);
    assign w_long_hit = (r_hold_cnt == HOLD_LAST) && !r_long_done;
    assign w_rel_done = (r_state == RELEASE_DB) && !w_k && w_db_done;

    always_ff @(posedge sysclk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:       if (w_k) w_next_state = PRESS_DB;
            PRESS_DB:   if (!w_k) w_next_state = IDLE;
                        else if (w_db_done) w_next_state = HELD;
            HELD:       if (!w_k) w_next_state = RELEASE_DB;
            RELEASE_DB: if (w_k) w_next_state = HELD;
                        else if (w_db_done) w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_db_cnt_nxt    = r_db_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_long_done_nxt = r_long_done;
        w_level_nxt     = r_level;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_speed_nxt     = r_speed;
        case (r_state)
            IDLE: if (w_k) w_db_cnt_nxt = '0;
            PRESS_DB: begin
                if (w_k && w_db_done) begin
                    w_level_nxt     = 1'b1;
                    w_press_nxt     = 1'b1;
                    w_hold_cnt_nxt  = '0;
                    w_long_done_nxt = 1'b0;
                    w_speed_nxt     = (r_speed == SPD_LAST) ? 2'd0 : r_speed + 2'd1;
                end else if (w_k) begin
                    w_db_cnt_nxt = r_db_cnt + 32'd1;
                end
            end
            HELD, RELEASE_DB: begin
                if (r_hold_cnt != HOLD_LAST) w_hold_cnt_nxt = r_hold_cnt + 32'd1;
                // A release completing on the long-press edge wins; long is dropped.
                if (w_long_hit && !w_rel_done) begin
                    w_long_nxt      = 1'b1;
                    w_long_done_nxt = 1'b1;
                    w_speed_nxt     = 2'd0;
                end
                if (r_state == HELD) begin
                    if (!w_k) w_db_cnt_nxt = '0;
                end else if (w_rel_done) begin
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else if (!w_k) begin
                    w_db_cnt_nxt = r_db_cnt + 32'd1;
                end
            end
            default: w_db_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_s1        <= ACTIVE_LOW;
            r_s2        <= ACTIVE_LOW;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_speed     <= 2'd0;
        end else begin
            r_s1        <= key_in;
            r_s2        <= r_s1;
            r_db_cnt    <= w_db_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_long_done <= w_long_done_nxt;
            r_level     <= w_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
            r_speed     <= w_speed_nxt;
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;
    assign speed_sel   = r_speed;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Bench for key_debounce_ctrl: directed test-plan scenarios plus random key
// waveforms, every cycle compared against a run-length based reference model.
module tb_key_debounce_ctrl;

    localparam int D    = 8;
    localparam int LONG = 40;
    localparam bit AL   = 1'b1;
    localparam int NS   = 4;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic       key_in = 1'b1;
    logic       key_level, key_press, key_release, key_long;
    logic [1:0] speed_sel;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic m_sh1, m_sh2, m_level, m_press, m_release, m_long, m_long_fired;
    int   m_run, m_age, m_speed;

    // DUT event log
    int dut_press_cyc, dut_release_cyc, dut_long_cyc;
    int n_press, n_release, n_long;

    key_debounce_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW       (AL),
        .NUM_SPEEDS       (NS)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .speed_sel  (speed_sel)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Debounced level flips once the pressed sense has disagreed with it on
    // D+1 consecutive edges; long fires LONG edges after the press edge.
    task automatic model_edge(input logic r, input logic key);
        logic k;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_long    = 1'b0;
        if (r) begin
            m_sh1 = AL; m_sh2 = AL; m_level = 1'b0; m_run = 0;
            m_age = -1; m_long_fired = 1'b0; m_speed = 0;
        end else begin
            k     = m_sh2 ^ AL;
            m_sh2 = m_sh1;
            m_sh1 = key;
            m_run = (k != m_level) ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_run = 0;
                if (!m_level) begin
                    m_level = 1'b1; m_press = 1'b1; m_age = 0; m_long_fired = 1'b0;
                    m_speed = (m_speed + 1) % NS;
                end else begin
                    m_level = 1'b0; m_release = 1'b1; m_age = -1;
                end
            end else if (m_level && m_age >= 0) begin
                m_age++;
                if (m_age == LONG && !m_long_fired) begin
                    m_long = 1'b1; m_long_fired = 1'b1; m_speed = 0;
                end
            end
        end
    endtask

    task automatic step(input logic key, input logic r);
        @(negedge sysclk);
        key_in = key;
        rst    = r;
        @(posedge sysclk);
        cyc++;
        model_edge(r, key);
        #1;
        chk("level",   {31'd0, key_level},   {31'd0, m_level});
        chk("press",   {31'd0, key_press},   {31'd0, m_press});
        chk("release", {31'd0, key_release}, {31'd0, m_release});
        chk("long",    {31'd0, key_long},    {31'd0, m_long});
        chk("speed",   {30'd0, speed_sel},   32'(m_speed));
        if (key_press === 1'b1)   begin dut_press_cyc = cyc;   n_press++;   end
        if (key_release === 1'b1) begin dut_release_cyc = cyc; n_release++; end
        if (key_long === 1'b1)    begin dut_long_cyc = cyc;    n_long++;    end
    endtask

    task automatic hold(input logic key, input int n);
        repeat (n) step(key, 1'b0);
    endtask

    task automatic clr_log();
        dut_press_cyc = -1; dut_release_cyc = -1; dut_long_cyc = -1;
        n_press = 0; n_release = 0; n_long = 0;
    endtask

    initial begin
        int t0;
        logic lvl;
        int len;
        clr_log();
        repeat (3) step(1'b1, 1'b1);
        chk("rst_level", {31'd0, key_level}, 32'd0);
        chk("rst_speed", {30'd0, speed_sel}, 32'd0);

        // clean press then release
        clr_log(); t0 = cyc;
        hold(1'b0, 30);
        chk("s1_press_lat", 32'(dut_press_cyc - t0), 32'd11);
        chk("s1_speed", {30'd0, speed_sel}, 32'd1);
        chk("s1_no_long", 32'(n_long), 32'd0);
        hold(1'b1, 30);

        // press bounce
        clr_log();
        hold(1'b0, 5); hold(1'b1, 2);
        t0 = cyc;
        hold(1'b0, 30);
        chk("s2_press_lat", 32'(dut_press_cyc - t0), 32'd11);
        chk("s2_press_cnt", 32'(n_press), 32'd1);

        // release bounce
        clr_log();
        hold(1'b1, 3); hold(1'b0, 1);
        t0 = cyc;
        hold(1'b1, 30);
        chk("s3_rel_lat", 32'(dut_release_cyc - t0), 32'd11);
        chk("s3_rel_cnt", 32'(n_release), 32'd1);
        chk("s3_press_cnt", 32'(n_press), 32'd0);
        chk("s3_level", {31'd0, key_level}, 32'd0);

        // long press
        clr_log();
        hold(1'b0, 60);
        chk("s4_long_lat", 32'(dut_long_cyc - dut_press_cyc), 32'd40);
        chk("s4_long_cnt", 32'(n_long), 32'd1);
        chk("s4_speed", {30'd0, speed_sel}, 32'd0);
        hold(1'b1, 30);
        chk("s4_rel_cnt", 32'(n_release), 32'd1);

        // speed wrap from reset
        repeat (2) step(1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            hold(1'b0, 15);
            chk("s5_speed", {30'd0, speed_sel}, 32'(i % NS));
            hold(1'b1, 15);
        end

        // reset while debouncing a press (db_cnt=5 after 8 edges)
        hold(1'b0, 15); hold(1'b1, 15);
        hold(1'b0, 8);
        clr_log();
        step(1'b0, 1'b1);
        chk("s6_level", {31'd0, key_level}, 32'd0);
        chk("s6_speed", {30'd0, speed_sel}, 32'd0);
        hold(1'b1, 20);
        chk("s6_no_pulse", 32'(n_press + n_release + n_long), 32'd0);
        t0 = cyc;
        hold(1'b0, 30);
        chk("s6_press_lat", 32'(dut_press_cyc - t0), 32'd11);
        hold(1'b1, 20);

        // random key waveforms with occasional reset
        repeat (300) begin
            lvl = 1'(($urandom_range(0, 1)));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 14);
            if ($urandom_range(0, 99) == 0) step(lvl, 1'b1);
            hold(lvl, len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
